// File: rtl/seq_detect_controller.sv
// Programmable serial sequence detector.
// A pattern of 1..MAX_LEN bits is loaded over a valid/ready config port, then
// detection is armed with start. Overlapping occurrences in the qualified bit
// stream raise a one-cycle detected pulse and bump a saturating match counter;
// an optional non-zero target stops detection once that many matches are seen.
module seq_detect_controller #(
   parameter  int MAX_LEN = 8,
   parameter  int CNT_W   = 8,
   localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic [CNT_W-1:0]   cfg_target,
   output logic               cfg_err,
   input  logic               start,
   input  logic               abort,
   input  logic               a_valid,
   input  logic               a,
   output logic               detected,
   output logic [CNT_W-1:0]   match_count,
   output logic               busy,
   output logic               done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // True when the low len bits of the window equal the low len bits of the pattern.
   // A len of MAX_LEN shifts every one out of the all-ones word, leaving a full mask.
   function automatic logic pattern_hit(
      input logic [MAX_LEN-1:0] window,
      input logic [MAX_LEN-1:0] pat,
      input logic [LEN_W-1:0]   len
   );
      logic [MAX_LEN-1:0] mask;
      mask = ~({MAX_LEN{1'b1}} << len);
      return ((window ^ pat) & mask) == {MAX_LEN{1'b0}};
   endfunction

   // Registered state
   logic [1:0]         state_r;
   logic               loaded_r;
   logic               cfg_err_r;
   logic [MAX_LEN-1:0] pattern_r;
   logic [LEN_W-1:0]   len_r;
   logic [CNT_W-1:0]   target_r;
   // Only the newest MAX_LEN-1 bits are kept: together with the incoming bit
   // they form the full MAX_LEN-bit compare window.
   logic [MAX_LEN-2:0] history_r;
   logic [LEN_W-1:0]   hist_cnt_r;
   logic [CNT_W-1:0]   match_count_r;
   logic               detected_r;

   // Next-state values
   logic [1:0]         state_nxt_s;
   logic               loaded_nxt_s;
   logic               cfg_err_nxt_s;
   logic [MAX_LEN-1:0] pattern_nxt_s;
   logic [LEN_W-1:0]   len_nxt_s;
   logic [CNT_W-1:0]   target_nxt_s;
   logic [MAX_LEN-2:0] history_nxt_s;
   logic [LEN_W-1:0]   hist_cnt_nxt_s;
   logic [CNT_W-1:0]   match_count_nxt_s;
   logic               detected_nxt_s;

   // Helpers
   logic               cfg_ready_s;
   logic               hs_s;
   logic               len_ok_s;
   logic [MAX_LEN-1:0] window_s;
   logic [LEN_W:0]     hist_inc_s;
   logic               hit_s;
   logic [CNT_W-1:0]   count_inc_s;

   // Handshake decode, shifted window, match test and saturating increments.
   always_comb begin
      cfg_ready_s = (state_r != ST_ARMED);
      hs_s        = cfg_valid & cfg_ready_s;
      len_ok_s    = (cfg_len != {LEN_W{1'b0}}) && (cfg_len <= LEN_W'(MAX_LEN));
      window_s    = {history_r, a};
      hist_inc_s  = {1'b0, hist_cnt_r} + {{LEN_W{1'b0}}, 1'b1};
      hit_s       = (hist_inc_s >= {1'b0, len_r}) && pattern_hit(window_s, pattern_r, len_r);
      if (match_count_r == {CNT_W{1'b1}}) begin
         count_inc_s = match_count_r;
      end else begin
         count_inc_s = match_count_r + CNT_W'(1);
      end
   end

   // Controller next-state: config beats start, abort beats a simultaneous match.
   always_comb begin
      state_nxt_s       = state_r;
      loaded_nxt_s      = loaded_r;
      cfg_err_nxt_s     = cfg_err_r;
      pattern_nxt_s     = pattern_r;
      len_nxt_s         = len_r;
      target_nxt_s      = target_r;
      history_nxt_s     = history_r;
      hist_cnt_nxt_s    = hist_cnt_r;
      match_count_nxt_s = match_count_r;
      detected_nxt_s    = 1'b0;

      if (hs_s) begin
         if (len_ok_s) begin
            pattern_nxt_s = cfg_pattern;
            len_nxt_s     = cfg_len;
            target_nxt_s  = cfg_target;
            loaded_nxt_s  = 1'b1;
            cfg_err_nxt_s = 1'b0;
            state_nxt_s   = ST_IDLE;
         end else begin
            cfg_err_nxt_s = 1'b1;
         end
      end else if (start && cfg_ready_s && loaded_r) begin
         state_nxt_s       = ST_ARMED;
         history_nxt_s     = {(MAX_LEN-1){1'b0}};
         hist_cnt_nxt_s    = {LEN_W{1'b0}};
         match_count_nxt_s = {CNT_W{1'b0}};
      end else if (state_r == ST_ARMED) begin
         if (abort) begin
            state_nxt_s = ST_IDLE;
         end else if (a_valid) begin
            history_nxt_s = window_s[MAX_LEN-2:0];
            if (hist_cnt_r == LEN_W'(MAX_LEN)) begin
               hist_cnt_nxt_s = hist_cnt_r;
            end else begin
               hist_cnt_nxt_s = hist_inc_s[LEN_W-1:0];
            end
            if (hit_s) begin
               detected_nxt_s    = 1'b1;
               match_count_nxt_s = count_inc_s;
               if ((target_r != {CNT_W{1'b0}}) && (count_inc_s == target_r)) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_ARMED;
               end
            end else begin
               detected_nxt_s = 1'b0;
            end
         end else begin
            detected_nxt_s = 1'b0;
         end
      end else begin
         detected_nxt_s = 1'b0;
      end

      case (state_nxt_s)
         ST_IDLE, ST_ARMED, ST_DONE: ;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State and output registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= ST_IDLE;
         loaded_r      <= 1'b0;
         cfg_err_r     <= 1'b0;
         pattern_r     <= {MAX_LEN{1'b0}};
         len_r         <= {LEN_W{1'b0}};
         target_r      <= {CNT_W{1'b0}};
         history_r     <= {(MAX_LEN-1){1'b0}};
         hist_cnt_r    <= {LEN_W{1'b0}};
         match_count_r <= {CNT_W{1'b0}};
         detected_r    <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         loaded_r      <= loaded_nxt_s;
         cfg_err_r     <= cfg_err_nxt_s;
         pattern_r     <= pattern_nxt_s;
         len_r         <= len_nxt_s;
         target_r      <= target_nxt_s;
         history_r     <= history_nxt_s;
         hist_cnt_r    <= hist_cnt_nxt_s;
         match_count_r <= match_count_nxt_s;
         detected_r    <= detected_nxt_s;
      end
   end

   assign cfg_ready   = cfg_ready_s;
   assign cfg_err     = cfg_err_r;
   assign detected    = detected_r;
   assign match_count = match_count_r;
   assign busy        = (state_r == ST_ARMED);
   assign done        = (state_r == ST_DONE);

endmodule

// File: tb/tb_seq_detect_controller.sv
// Self-checking bench for seq_detect_controller: directed scenarios followed by
// randomized traffic, every cycle compared against a queue-based reference model.
module tb_seq_detect_controller;

   localparam int MAX_LEN = 8;
   localparam int CNT_W   = 8;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);
   localparam int S_IDLE  = 0;
   localparam int S_ARMED = 1;
   localparam int S_DONE  = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic               cfg_valid;
   logic               cfg_ready;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic [CNT_W-1:0]   cfg_target;
   logic               cfg_err;
   logic               start;
   logic               abort;
   logic               a_valid;
   logic               a;
   logic               detected;
   logic [CNT_W-1:0]   match_count;
   logic               busy;
   logic               done;

   int checks   = 0;
   int failures = 0;
   int det_seen = 0;

   // Reference model: spec-level state and a queue of bits received since start
   int       m_state;
   bit       m_loaded;
   bit       m_err;
   bit [7:0] m_pat;
   int       m_len;
   int       m_tgt;
   int       m_cnt;
   bit       m_det;
   bit       hq[$];

   seq_detect_controller #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_target(cfg_target), .cfg_err(cfg_err),
      .start(start), .abort(abort), .a_valid(a_valid), .a(a),
      .detected(detected), .match_count(match_count), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state  = S_IDLE;
      m_loaded = 1'b0;
      m_err    = 1'b0;
      m_pat    = 8'd0;
      m_len    = 0;
      m_tgt    = 0;
      m_cnt    = 0;
      m_det    = 1'b0;
      hq.delete();
   endtask

   // Last m_len received bits, newest first, must equal pattern bits 0..m_len-1.
   function automatic bit model_hit();
      if (hq.size() < m_len) return 1'b0;
      for (int i = 0; i < m_len; i++) begin
         if (hq[hq.size()-1-i] != m_pat[i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_step();
      bit hs;
      hs    = cfg_valid && (m_state != S_ARMED);
      m_det = 1'b0;
      if (hs) begin
         if (cfg_len >= 1 && cfg_len <= MAX_LEN) begin
            m_pat    = cfg_pattern;
            m_len    = int'(cfg_len);
            m_tgt    = int'(cfg_target);
            m_loaded = 1'b1;
            m_err    = 1'b0;
            m_state  = S_IDLE;
         end else begin
            m_err = 1'b1;
         end
      end else if (start && m_loaded && m_state != S_ARMED) begin
         m_state = S_ARMED;
         m_cnt   = 0;
         hq.delete();
      end else if (m_state == S_ARMED) begin
         if (abort) begin
            m_state = S_IDLE;
         end else if (a_valid) begin
            hq.push_back(a);
            if (hq.size() > MAX_LEN) void'(hq.pop_front());
            if (model_hit()) begin
               m_det = 1'b1;
               if (m_cnt < 255) m_cnt++;
               if (m_tgt != 0 && m_cnt == m_tgt) m_state = S_DONE;
            end
         end
      end
   endtask

   task automatic check_all();
      chk("detected",    detected,    m_det);
      chk("match_count", match_count, m_cnt);
      chk("busy",        busy,        m_state == S_ARMED);
      chk("done",        done,        m_state == S_DONE);
      chk("cfg_ready",   cfg_ready,   m_state != S_ARMED);
      chk("cfg_err",     cfg_err,     m_err);
   endtask

   task automatic clear_inputs();
      cfg_valid   = 1'b0;
      cfg_pattern = '0;
      cfg_len     = '0;
      cfg_target  = '0;
      start       = 1'b0;
      abort       = 1'b0;
      a_valid     = 1'b0;
      a           = 1'b0;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
      if (detected === 1'b1) det_seen++;
      clear_inputs();
   endtask

   task automatic do_cfg(input logic [7:0] pat, input int len, input int tgt);
      cfg_valid   = 1'b1;
      cfg_pattern = pat;
      cfg_len     = LEN_W'(len);
      cfg_target  = CNT_W'(tgt);
      tick();
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick();
   endtask

   task automatic send_bit(input logic b);
      a_valid = 1'b1;
      a       = b;
      tick();
   endtask

   task automatic send_bits(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
   endtask

   initial begin
      rst = 1'b0;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b1;

      // Illegal length: sticky error, start ignored while unconfigured
      do_cfg(8'h00, 0, 0);
      chk("t3_err_set", cfg_err, 1'b1);
      do_start();
      chk("t3_busy_idle", busy, 1'b0);
      do_cfg(8'b1010, 4, 0);
      chk("t3_err_clear", cfg_err, 1'b0);

      // Overlapping detection of 110011 in 1100110011
      do_cfg(8'b110011, 6, 0);
      do_start();
      det_seen = 0;
      send_bits(16'b1100110011, 10);
      chk("t1_count", match_count, 8'd2);
      chk("t1_pulses", det_seen, 2);

      // Target of one: DONE after first match, trailing bits ignored
      do_abort();
      do_cfg(8'b110011, 6, 1);
      do_start();
      det_seen = 0;
      send_bits(16'b110011, 6);
      chk("t2_done", done, 1'b1);
      send_bits(16'b0011, 4);
      chk("t2_count", match_count, 8'd1);
      chk("t2_pulses", det_seen, 1);

      // Abort then restart clears history
      do_cfg(8'b1010, 4, 0);
      do_start();
      send_bits(16'b101, 3);
      do_abort();
      do_start();
      det_seen = 0;
      send_bit(1'b0);
      chk("t4_count", match_count, 8'd0);
      chk("t4_pulses", det_seen, 0);

      // Gaps in a_valid are transparent
      do_abort();
      do_cfg(8'b1010, 4, 0);
      do_start();
      det_seen = 0;
      send_bits(16'b10, 2);
      repeat (3) tick();
      send_bits(16'b10, 2);
      chk("t5_pulses", det_seen, 1);
      chk("t5_count", match_count, 8'd1);

      // Counter saturation with a one-bit pattern
      do_abort();
      do_cfg(8'b1, 1, 0);
      do_start();
      for (int i = 0; i < 260; i++) send_bit(1'b1);
      chk("sat_count", match_count, 8'd255);
      chk("sat_busy", busy, 1'b1);

      // Asynchronous reset mid-ARMED
      do_abort();
      do_cfg(8'b1010, 4, 0);
      do_start();
      send_bits(16'b1010, 4);
      #2;
      rst = 1'b0;
      #1;
      chk("t6_busy", busy, 1'b0);
      chk("t6_done", done, 1'b0);
      chk("t6_detected", detected, 1'b0);
      chk("t6_count", match_count, 8'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      do_start();
      chk("t6_start_ignored", busy, 1'b0);
      do_cfg(8'b1010, 4, 0);
      do_start();
      chk("t6_rearm", busy, 1'b1);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) < 4) begin
            cfg_valid   = 1'b1;
            cfg_pattern = MAX_LEN'($urandom);
            if ($urandom_range(0, 9) < 8) cfg_len = LEN_W'($urandom_range(1, 4));
            else cfg_len = LEN_W'($urandom_range(0, 10));
            cfg_target  = CNT_W'($urandom_range(0, 4));
         end
         start   = ($urandom_range(0, 99) < 8);
         abort   = ($urandom_range(0, 99) < 2);
         a_valid = ($urandom_range(0, 99) < 70);
         a       = $urandom_range(0, 1);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
